rs_c1_single_corrector: RTL and testbench

RS_C1_SINGLE_CORRECTOR -- requirements
Module: rs_c1_single_corrector

---
 rtl/rs_c1_pkg.sv | 21 ++
 rtl/gf256_inv.sv | 19 +
 rtl/gf256_mul.sv | 10 +
 rtl/rs_c1_single_corrector.sv | 110 +++++++++++
 tb/tb_rs_c1_single_corrector.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/rs_c1_pkg.sv
// rs_c1_pkg: shared GF(256) constants, status codes and FSM states for the C1 single-error corrector
package rs_c1_pkg;
    localparam logic [7:0] GF_POLY  = 8'h1D;
    localparam logic [7:0] GF_ALPHA = 8'h02;
    localparam int         C1_LEN   = 32;
    localparam logic [1:0] ST_NONE   = 2'b00;
    localparam logic [1:0] ST_FIXED  = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;
    typedef enum logic [1:0] {IDLE, CHECK, SEARCH, DONE} state_t;
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
        end
        return p;
    endfunction
endpackage

// File: rtl/gf256_inv.sv
// gf256_inv: combinational GF(256) inverse as a^254 (maps 0 to 0)
module gf256_inv
    import rs_c1_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] sq;
    logic [7:0] acc;
    always_comb begin
        sq  = a_i;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        y_o = acc;
    end
endmodule

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(256) multiplier over 0x11D
module gf256_mul
    import rs_c1_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] y_o
);
    assign y_o = gf_mul(a_i, b_i);
endmodule

// File: rtl/rs_c1_single_corrector.sv
// rs_c1_single_corrector: checks C1 syndromes for a single error and locates it by
// stepping alpha^k until it matches the locator X = S1/S0.
module rs_c1_single_corrector
    import rs_c1_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_resb,
    input  logic       i_synd_valid,
    input  logic [7:0] i_s0,
    input  logic [7:0] i_s1,
    input  logic [7:0] i_s2,
    input  logic [7:0] i_s3,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_status,
    output logic [4:0] o_err_pos,
    output logic [7:0] o_err_val,
    output logic       o_drop
);
    state_t          state_q, state_d;
    logic [3:0][7:0] s_q;
    logic [7:0]      tgt_q, tgt_d, pwr_q, pwr_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [7:0]      inv_s0, x, p2, p3, pwr_next;
    logic            fin, consistent;
    logic [1:0]      res_status;
    logic [4:0]      res_pos;
    logic [7:0]      res_val;

    gf256_inv u_inv (.a_i(s_q[0]), .y_o(inv_s0));
    gf256_mul u_x   (.a_i(s_q[1]), .b_i(inv_s0),   .y_o(x));
    gf256_mul u_p2  (.a_i(s_q[1]), .b_i(x),        .y_o(p2));
    gf256_mul u_p3  (.a_i(s_q[2]), .b_i(x),        .y_o(p3));
    gf256_mul u_stp (.a_i(pwr_q),  .b_i(GF_ALPHA), .y_o(pwr_next));

    // a single error gives a geometric syndrome sequence with ratio X
    assign consistent = (s_q[0] != 8'h00) && (s_q[1] != 8'h00) && (s_q[2] == p2) && (s_q[3] == p3);

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        pwr_d      = pwr_q;
        cnt_d      = cnt_q;
        fin        = 1'b0;
        res_status = ST_UNCORR;
        res_pos    = '0;
        res_val    = '0;
        case (state_q)
            IDLE:   if (i_synd_valid) state_d = CHECK;
            CHECK: begin
                if (s_q == '0) begin
                    fin        = 1'b1;
                    res_status = ST_NONE;
                end else if (!consistent) begin
                    fin = 1'b1;
                end else begin
                    tgt_d   = x;
                    pwr_d   = 8'h01;
                    cnt_d   = '0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (pwr_q == tgt_q) begin
                    fin        = 1'b1;
                    res_status = ST_FIXED;
                    res_pos    = cnt_q;
                    res_val    = s_q[0];
                end else if (cnt_q == 5'(C1_LEN - 1)) begin
                    fin = 1'b1;
                end else begin
                    pwr_d = pwr_next;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fin) state_d = DONE;
    end

    always_ff @(posedge i_clk or negedge i_resb) begin
        if (!i_resb) begin
            state_q   <= IDLE;
            s_q       <= '0;
            tgt_q     <= '0;
            pwr_q     <= '0;
            cnt_q     <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_drop    <= 1'b0;
            o_status  <= ST_NONE;
            o_err_pos <= '0;
            o_err_val <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            pwr_q   <= pwr_d;
            cnt_q   <= cnt_d;
            o_busy  <= (state_d != IDLE);
            o_done  <= fin;
            o_drop  <= i_synd_valid && (state_q != IDLE);
            if (state_q == IDLE && i_synd_valid) s_q <= {i_s3, i_s2, i_s1, i_s0};
            if (fin) begin
                o_status  <= res_status;
                o_err_pos <= res_pos;
                o_err_val <= res_val;
            end
        end
    end
endmodule

// File: tb/tb_rs_c1_single_corrector.sv
// tb_rs_c1_single_corrector: directed vectors with a scoreboard of expected results and drops
module tb_rs_c1_single_corrector;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic       busy, done, drop;
    logic [1:0] status;
    logic [4:0] pos;
    logic [7:0] val;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {int st; int pos; int val; int cyc;} exp_t;
    exp_t exp_q[$];
    int   drop_q[$];

    rs_c1_single_corrector dut (
        .i_clk(clk), .i_resb(rst_n), .i_synd_valid(valid),
        .i_s0(s0), .i_s1(s1), .i_s2(s2), .i_s3(s3),
        .o_busy(busy), .o_done(done), .o_status(status),
        .o_err_pos(pos), .o_err_val(val), .o_drop(drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < n; i++) r = gmul(r, 8'h02);
        return r;
    endfunction

    // syndromes of a single error e at locator exponent j: Sk = e * alpha^(j*k)
    function automatic logic [31:0] synd(input logic [7:0] e, input int j);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[8*k +: 8] = gmul(e, gpow(j * k));
        return v;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: got status %0d expected no result", cyc, status);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("status", int'(status), e.st);
                chk("err_pos", int'(pos), e.pos);
                chk("err_val", int'(val), e.val);
            end
        end
        if (drop) begin
            if (drop_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_drop at cycle %0d: got 1 expected 0", cyc);
            end else chk("drop_cycle", cyc, drop_q.pop_front());
        end
    end

    task automatic issue(input logic [31:0] v, input bit push, input int st, input int p, input int vl, input int lat);
        {s3, s2, s1, s0} = v;
        valid = 1'b1;
        if (push) exp_q.push_back('{st, p, vl, cyc + lat});
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (exp_q.size() != 0 || drop_q.size() != 0); i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || drop_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results %0d drops pending expected 0", exp_q.size(), drop_q.size());
            exp_q.delete();
            drop_q.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_drop"}, int'(drop), 0);
        chk({tag, "_status"}, int'(status), 0);
        chk({tag, "_pos"}, int'(pos), 0);
        chk({tag, "_val"}, int'(val), 0);
    endtask

    initial begin
        logic [31:0] v;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        issue(32'h0, 1, 0, 0, 0, 2);
        drain();
        issue(synd(8'h3C, 5), 1, 1, 5, 8'h3C, 8);
        drain();
        issue(synd(8'h01, 31), 1, 1, 31, 8'h01, 34);
        drain();
        issue(32'h00_08_02_01, 1, 2, 0, 0, 2);
        drain();
        issue(synd(8'h55, 40), 1, 2, 0, 0, 34);
        drain();
        issue(synd(8'h77, 0), 1, 1, 0, 8'h77, 3);
        drain();
        issue(32'h00_09_00_00, 1, 2, 0, 0, 2);
        drain();
        issue(32'h00_00_00_05, 1, 2, 0, 0, 2);
        drain();
        v = synd(8'h11, 3);
        v[31:24] = v[31:24] ^ 8'h01;
        issue(v, 1, 2, 0, 0, 2);
        drain();
        // a strobe during SEARCH is dropped and leaves the first search intact
        issue(synd(8'hA5, 10), 1, 1, 10, 8'hA5, 13);
        repeat (3) @(negedge clk);
        drop_q.push_back(cyc + 1);
        issue(32'hDEADBEEF, 0, 0, 0, 0, 0);
        drain();
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
        // reset pulsed mid-SEARCH aborts with no result
        issue(synd(8'h3C, 5), 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done_status", int'(status), 0);
        issue(synd(8'h3C, 2), 1, 1, 2, 8'h3C, 5);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
